// File: rtl/async_mem_wb_master.sv
`default_nettype none
// ============================================================================
// Module : async_mem_wb_master
// Bridges an asynchronous SRAM-style host bus onto single classic Wishbone
// master cycles, stalling the host through mem_wait_n until the cycle resolves.
// Rev    : 1.0  initial release
// ============================================================================
module async_mem_wb_master #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int MAX_RETRY   = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_ce_n,
  input  logic                mem_oe_n,
  input  logic                mem_we_n,
  input  logic [DWIDTH/8-1:0] mem_be_n,
  input  logic [AWIDTH-1:0]   mem_a,
  input  logic [DWIDTH-1:0]   mem_d_i,
  output logic [DWIDTH-1:0]   mem_d_o,
  output logic                mem_d_oe,
  output logic                mem_wait_n,
  output logic [AWIDTH-1:0]   adr_o,
  output logic [DWIDTH-1:0]   dat_o,
  input  logic [DWIDTH-1:0]   dat_i,
  output logic [DWIDTH/8-1:0] sel_o,
  output logic                we_o,
  output logic                cyc_o,
  output logic                stb_o,
  input  logic                ack_i,
  input  logic                err_i,
  input  logic                rty_i,
  output logic                bus_err_o
);

  localparam int c_TW = $clog2(TIMEOUT + 1);
  localparam int c_RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_LAUNCH    = 3'd1;
  localparam logic [2:0] c_WAIT_ACK  = 3'd2;
  localparam logic [2:0] c_RETRY_GAP = 3'd3;
  localparam logic [2:0] c_DONE      = 3'd4;

  logic [SYNC_STAGES-1:0] r_ce_sync, r_oe_sync, r_we_sync;
  logic [2:0]             r_state, w_state_nxt;
  logic [c_TW-1:0]        r_tmo;
  logic [c_RW-1:0]        r_retry;
  logic                   w_ce_s, w_oe_s, w_we_s;
  logic                   w_wr_req, w_rd_req, w_req;
  logic                   w_can_retry, w_tmo_hit, w_fail, w_retry;

  // Strobes idle high so the synchronisers reset to "deasserted".
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ce_sync <= '1;
      r_oe_sync <= '1;
      r_we_sync <= '1;
    end else begin
      r_ce_sync <= {r_ce_sync[SYNC_STAGES-2:0], mem_ce_n};
      r_oe_sync <= {r_oe_sync[SYNC_STAGES-2:0], mem_oe_n};
      r_we_sync <= {r_we_sync[SYNC_STAGES-2:0], mem_we_n};
    end
  end

  assign w_ce_s   = r_ce_sync[SYNC_STAGES-1];
  assign w_oe_s   = r_oe_sync[SYNC_STAGES-1];
  assign w_we_s   = r_we_sync[SYNC_STAGES-1];
  assign w_wr_req = ~w_ce_s & ~w_we_s;
  assign w_rd_req = ~w_ce_s & ~w_oe_s & w_we_s;
  assign w_req    = w_wr_req | w_rd_req;

  // Resolution priority: ack > err > rty > timeout; exhausted retries count as errors.
  assign w_can_retry = (r_retry < c_RW'(MAX_RETRY));
  assign w_tmo_hit   = (r_tmo == c_TW'(TIMEOUT - 1));
  assign w_fail      = ~ack_i & (err_i | (rty_i & ~w_can_retry) | (~rty_i & w_tmo_hit));
  assign w_retry     = ~ack_i & ~err_i & rty_i & w_can_retry;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:      if (w_req) w_state_nxt = c_LAUNCH;
      c_LAUNCH:    w_state_nxt = c_WAIT_ACK;
      c_WAIT_ACK: begin
        if (ack_i || w_fail) w_state_nxt = c_DONE;
        else if (w_retry)    w_state_nxt = c_RETRY_GAP;
      end
      c_RETRY_GAP: w_state_nxt = c_LAUNCH;
      c_DONE:      if (w_ce_s || (w_oe_s && w_we_s)) w_state_nxt = c_IDLE;
      default:     w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    cyc_o      = 1'b0;
    stb_o      = 1'b0;
    mem_wait_n = 1'b1;
    mem_d_oe   = 1'b0;
    case (r_state)
      c_IDLE:                mem_wait_n = ~w_req;
      c_LAUNCH, c_RETRY_GAP: mem_wait_n = 1'b0;
      c_WAIT_ACK: begin
        cyc_o      = 1'b1;
        stb_o      = 1'b1;
        mem_wait_n = 1'b0;
      end
      c_DONE:                mem_d_oe = ~we_o & ~w_ce_s & ~w_oe_s;
      default: ;
    endcase
  end

  // Host address/data/byte-enables are quasi-static and latched once at launch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      adr_o     <= '0;
      dat_o     <= '0;
      sel_o     <= '0;
      we_o      <= 1'b0;
      mem_d_o   <= '0;
      bus_err_o <= 1'b0;
      r_tmo     <= '0;
      r_retry   <= '0;
    end else begin
      case (r_state)
        c_IDLE: if (w_req) begin
          adr_o   <= mem_a;
          dat_o   <= mem_d_i;
          sel_o   <= ~mem_be_n;
          we_o    <= w_wr_req;
          r_retry <= '0;
        end
        c_LAUNCH: r_tmo <= '0;
        c_WAIT_ACK: begin
          r_tmo <= r_tmo + 1'b1;
          if (ack_i) begin
            if (!we_o) mem_d_o <= dat_i;
          end else if (w_fail) begin
            bus_err_o <= 1'b1;
            if (!we_o) mem_d_o <= '1;
          end else if (w_retry) begin
            r_retry <= r_retry + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_async_mem_wb_master.sv
`default_nettype none
// ============================================================================
// Module : tb_async_mem_wb_master
// Directed bench: host-bus driver, behavioural Wishbone slave memory and a
// byte-level reference memory that predicts every access outcome.
// Rev    : 1.0  initial release
// ============================================================================
module tb_async_mem_wb_master;

  localparam int SYNC = 2;
  localparam int TMO  = 8;
  localparam int MAXR = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        mem_ce_n = 1'b1, mem_oe_n = 1'b1, mem_we_n = 1'b1;
  logic [3:0]  mem_be_n = 4'hF;
  logic [7:0]  mem_a = 8'h00;
  logic [31:0] mem_d_i = 32'h0;
  logic [31:0] mem_d_o, dat_o, dat_i;
  logic        mem_d_oe, mem_wait_n, we_o, cyc_o, stb_o, ack_i, err_i, rty_i, bus_err_o;
  logic [7:0]  adr_o;
  logic [3:0]  sel_o;

  async_mem_wb_master #(
    .DWIDTH(32), .AWIDTH(8), .SYNC_STAGES(SYNC), .TIMEOUT(TMO), .MAX_RETRY(MAXR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_be_n(mem_be_n), .mem_a(mem_a), .mem_d_i(mem_d_i),
    .mem_d_o(mem_d_o), .mem_d_oe(mem_d_oe), .mem_wait_n(mem_wait_n),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o), .we_o(we_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
    .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural slave: responds after s_delay cycles of stb, giving s_rty_cfg retries first.
  logic [7:0] smem [0:255];
  int s_cnt = 0, s_delay = 1, s_rty_cfg = 0, s_rty_base = 0, s_rty_given = 0, s_err_mode = 0;
  bit s_silent = 1'b0;
  logic s_resp;

  always_comb begin
    s_resp = stb_o && !s_silent && (s_cnt >= s_delay);
    rty_i  = s_resp && ((s_rty_given - s_rty_base) < s_rty_cfg);
    ack_i  = s_resp && !rty_i && (s_err_mode != 1);
    err_i  = s_resp && !rty_i && (s_err_mode != 0);
    dat_i  = {smem[adr_o + 8'd3], smem[adr_o + 8'd2], smem[adr_o + 8'd1], smem[adr_o]};
  end

  always @(posedge clk_i) begin
    if (stb_o && !s_resp) s_cnt <= s_cnt + 1;
    else                  s_cnt <= 0;
    if (rty_i) s_rty_given <= s_rty_given + 1;
    if (ack_i && we_o)
      for (int b = 0; b < 4; b++)
        if (sel_o[b]) smem[adr_o + 8'(b)] <= dat_o[8*b +: 8];
  end

  int edge_cnt = 0;
  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  // Reference model state.
  logic [7:0]  mm [0:255];
  logic [7:0]  exp_adr = 8'h00;
  logic [31:0] exp_dat = 32'h0;
  logic [3:0]  exp_sel = 4'h0;
  logic        exp_we = 1'b0;
  bit          exp_sticky = 1'b0;

  function automatic logic [31:0] model_word(input logic [7:0] a);
    return {mm[a + 8'd3], mm[a + 8'd2], mm[a + 8'd1], mm[a]};
  endfunction

  function automatic logic [31:0] slave_word(input logic [7:0] a);
    return {smem[a + 8'd3], smem[a + 8'd2], smem[a + 8'd1], smem[a]};
  endfunction

  int         rise_q[$];
  logic [7:0] radr_q[$];
  logic [3:0] rsel_q[$];
  logic       rwe_q[$];
  int         cur_len = 0, last_len = 0;
  logic       prev_stb = 1'b0;

  // Per-cycle compare process plus pulse bookkeeping.
  always @(negedge clk_i) begin
    if (stb_o && !prev_stb) begin
      rise_q.push_back(edge_cnt);
      radr_q.push_back(adr_o);
      rsel_q.push_back(sel_o);
      rwe_q.push_back(we_o);
      cur_len = 1;
    end else if (stb_o) begin
      cur_len++;
    end
    if (!stb_o && prev_stb) last_len = cur_len;
    prev_stb = stb_o;
    if (rst_i) begin
      chk("cyc_eq_stb", 32'(cyc_o), 32'(stb_o));
      if (stb_o) begin
        chk("adr_o", 32'(adr_o), 32'(exp_adr));
        chk("sel_o", 32'(sel_o), 32'(exp_sel));
        chk("we_o", 32'(we_o), 32'(exp_we));
        if (exp_we) chk("dat_o", dat_o, exp_dat);
        chk("wait_n_busy", 32'(mem_wait_n), 32'd0);
      end
      if (mem_d_oe) chk("d_oe_on_write", 32'(exp_we), 32'd0);
    end
  end

  task automatic do_access(input bit wr, input bit both, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] ben, input int rty_n, input int delay,
                           input bit silent, input int emode, output logic [31:0] rdata);
    int  base, n, exp_pulses, exp_len, fall;
    bit  fail;
    s_rty_cfg  = rty_n;
    s_rty_base = s_rty_given;
    s_delay    = delay;
    s_silent   = silent;
    s_err_mode = emode;
    fail       = silent || (emode == 1) || (rty_n > MAXR);
    exp_pulses = silent ? 1 : ((rty_n > MAXR) ? MAXR + 1 : rty_n + 1);
    exp_len    = silent ? TMO : delay + 1;
    @(negedge clk_i);
    base = rise_q.size();
    exp_adr = a; exp_dat = d; exp_sel = ~ben; exp_we = wr;
    mem_a = a; mem_d_i = d; mem_be_n = ben;
    mem_ce_n = 1'b0;
    if (wr) begin
      mem_we_n = 1'b0;
      if (both) mem_oe_n = 1'b0;
    end else begin
      mem_oe_n = 1'b0;
    end
    fall = edge_cnt;
    n = 0;
    while (mem_wait_n && n < 20) begin @(negedge clk_i); n++; end
    chk("wait_n_low", 32'(mem_wait_n), 32'd0);
    n = 0;
    while (!mem_wait_n && n < 200) begin @(negedge clk_i); n++; end
    chk("wait_n_high", 32'(mem_wait_n), 32'd1);
    #1;
    chk("pulses", 32'(rise_q.size() - base), 32'(exp_pulses));
    if (rise_q.size() > base) chk("latency", 32'(rise_q[base] - fall), 32'(SYNC + 2));
    chk("last_len", 32'(last_len), 32'(exp_len));
    if (wr && !fail)
      for (int b = 0; b < 4; b++)
        if (!ben[b]) mm[a + 8'(b)] = d[8*b +: 8];
    exp_sticky = exp_sticky | fail;
    chk("bus_err", 32'(bus_err_o), 32'(exp_sticky));
    if (!wr) begin
      chk("rd_data", mem_d_o, fail ? 32'hFFFF_FFFF : model_word(a));
      chk("d_oe_on", 32'(mem_d_oe), 32'd1);
    end else begin
      chk("slave_mem", slave_word(a), model_word(a));
    end
    rdata = mem_d_o;
    @(negedge clk_i);
    if (!wr) chk("d_oe_hold", 32'(mem_d_oe), 32'd1);
    mem_ce_n = 1'b1; mem_oe_n = 1'b1; mem_we_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk_i);
    chk("d_oe_off", 32'(mem_d_oe), 32'd0);
    chk("idle_wait_n", 32'(mem_wait_n), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    for (int i = 0; i < 256; i++) begin smem[i] = 8'h00; mm[i] = 8'h00; end

    // Reset values.
    #12;
    chk("rst_cyc", 32'(cyc_o), 32'd0);
    chk("rst_stb", 32'(stb_o), 32'd0);
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_adr", 32'(adr_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_sel", 32'(sel_o), 32'd0);
    chk("rst_mem_d_o", mem_d_o, 32'd0);
    chk("rst_d_oe", 32'(mem_d_oe), 32'd0);
    chk("rst_wait_n", 32'(mem_wait_n), 32'd1);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Full-word write.
    do_access(1, 0, 8'h10, 32'hDEAD_BEEF, 4'b0000, 0, 1, 0, 0, rd);
    chk("wr_adr_lit", 32'(radr_q[$]), 32'h10);
    chk("wr_sel_lit", 32'(rsel_q[$]), 32'hF);
    chk("wr_we_lit", 32'(rwe_q[$]), 32'd1);
    chk("wr_bytes_lit", slave_word(8'h10), 32'hDEAD_BEEF);
    chk("wr_byte10_lit", 32'(smem[8'h10]), 32'hEF);
    chk("wr_byte13_lit", 32'(smem[8'h13]), 32'hDE);

    // Read with two-cycle acknowledge delay.
    do_access(0, 0, 8'h10, 32'h0, 4'b0000, 0, 2, 0, 0, rd);
    chk("rd_data_lit", rd, 32'hDEAD_BEEF);
    chk("rd_stb_len_lit", 32'(last_len), 32'd3);

    // Single-byte write then read-back.
    do_access(1, 0, 8'h10, 32'h0000_AA00, 4'b1101, 0, 1, 0, 0, rd);
    chk("bw_sel_lit", 32'(rsel_q[$]), 32'b0010);
    chk("bw_b10_lit", 32'(smem[8'h10]), 32'hEF);
    chk("bw_b11_lit", 32'(smem[8'h11]), 32'hAA);
    chk("bw_b12_lit", 32'(smem[8'h12]), 32'hAD);
    do_access(0, 0, 8'h10, 32'h0, 4'b0000, 0, 1, 0, 0, rd);
    chk("bw_readback_lit", rd, 32'hDEAD_AAEF);

    // Write with oe and we both low, then read back at a second address.
    do_access(1, 1, 8'h20, 32'h1234_5678, 4'b0000, 0, 1, 0, 0, rd);
    chk("both_low_we_lit", 32'(rwe_q[$]), 32'd1);
    do_access(0, 0, 8'h20, 32'h0, 4'b0000, 0, 0, 0, 0, rd);
    chk("both_low_rd_lit", rd, 32'h1234_5678);

    // ack and err in the same cycle: ack wins.
    do_access(0, 0, 8'h10, 32'h0, 4'b0000, 0, 1, 0, 2, rd);
    chk("prio_rd_lit", rd, 32'hDEAD_AAEF);
    chk("prio_err_lit", 32'(bus_err_o), 32'd0);

    // Two retries then ack.
    do_access(0, 0, 8'h10, 32'h0, 4'b0000, 2, 1, 0, 0, rd);
    chk("rty2_rd_lit", rd, 32'hDEAD_AAEF);
    chk("rty2_err_lit", 32'(bus_err_o), 32'd0);

    // Retry every attempt: exhausted after four strobes.
    do_access(0, 0, 8'h10, 32'h0, 4'b0000, 10, 1, 0, 0, rd);
    chk("rty_ex_rd_lit", rd, 32'hFFFF_FFFF);
    chk("rty_ex_err_lit", 32'(bus_err_o), 32'd1);

    // Silent slave: timeout.
    do_access(0, 0, 8'h30, 32'h0, 4'b0000, 0, 1, 1, 0, rd);
    chk("tmo_len_lit", 32'(last_len), 32'd8);
    chk("tmo_err_lit", 32'(bus_err_o), 32'd1);

    // Reset while the Wishbone cycle is outstanding.
    s_silent = 1'b1; s_rty_cfg = 0; s_rty_base = s_rty_given; s_err_mode = 0;
    @(negedge clk_i);
    exp_adr = 8'h30; exp_sel = 4'hF; exp_we = 1'b0;
    mem_a = 8'h30; mem_be_n = 4'h0; mem_ce_n = 1'b0; mem_oe_n = 1'b0;
    n = 0;
    while (!stb_o && n < 20) begin @(negedge clk_i); n++; end
    chk("rstmid_stb_seen", 32'(stb_o), 32'd1);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    chk("rstmid_cyc", 32'(cyc_o), 32'd0);
    chk("rstmid_stb", 32'(stb_o), 32'd0);
    chk("rstmid_wait_n", 32'(mem_wait_n), 32'd1);
    chk("rstmid_bus_err", 32'(bus_err_o), 32'd0);
    exp_sticky = 1'b0;
    mem_ce_n = 1'b1; mem_oe_n = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    s_silent = 1'b0;
    repeat (2) @(negedge clk_i);
    do_access(0, 0, 8'h10, 32'h0, 4'b0000, 0, 1, 0, 0, rd);
    chk("post_rst_rd_lit", rd, 32'hDEAD_AAEF);
    chk("post_rst_err_lit", 32'(bus_err_o), 32'd0);

    // Plain err_i response on a read.
    do_access(0, 0, 8'h20, 32'h0, 4'b0000, 0, 1, 0, 1, rd);
    chk("err_rd_lit", rd, 32'hFFFF_FFFF);
    chk("err_flag_lit", 32'(bus_err_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
